// File: rtl/win_offset_encoder.sv
// win_offset_encoder
// Encodes signed sample offsets (dx, dy) around a keypoint into the 8-bit
// descriptor-window index {row, col}, with row = CENTER - dy and
// col = CENTER - dx. It flags offsets outside the 16x16 window and keeps
// per-frame handshake counts. The datapath is a 2-stage valid/ready pipeline.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  input handshake (in_ready is combinational)
//   in_dx, in_dy    5-bit two's-complement offsets
//   in_last         last sample of the frame
//   out_valid/ready output handshake
//   out_idx         {row[3:0], col[3:0]}
//   out_oob         offset outside the window
//   out_last        in_last carried through the pipeline
//   cnt, oob_cnt    saturating per-frame handshake / out-of-bounds counts
//   frame_done      one-cycle pulse after the out_last handshake
//   err             sticky error flag, clr_err clears it synchronously
module win_offset_encoder #(
  parameter int unsigned CENTER    = 8,
  parameter int unsigned FRAME_LEN = 256,
  localparam int unsigned OFS_W    = 5,
  localparam int unsigned IDX_W    = 8,
  localparam int unsigned CNT_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OFS_W-1:0] in_dx,
  input  logic [OFS_W-1:0] in_dy,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_oob,
  output logic             out_last,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] oob_cnt,
  output logic             frame_done,
  output logic             err,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [OFS_W-1:0] s1_dx;
  logic [OFS_W-1:0] s1_dy;
  logic             s1_last;

  logic             s2_adv;
  logic             s1_adv;
  logic             hs;
  logic [OFS_W-1:0] col5;
  logic [OFS_W-1:0] row5;
  logic [CNT_W-1:0] cnt_p1;
  logic [CNT_W-1:0] oob_cnt_p1;
  logic             err_set;

  // Handshake / stall control; a stage advances when empty or its successor moves.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign hs       = out_valid && out_ready;

  // 5-bit wrap: bit 4 set means the coordinate left the 0..15 window.
  assign col5 = OFS_W'(OFS_W'(CENTER) - s1_dx);
  assign row5 = OFS_W'(OFS_W'(CENTER) - s1_dy);

  // cnt + 1 wraps at 9 bits, so a saturated count never matches FRAME_LEN.
  assign cnt_p1     = CNT_W'(cnt + CNT_W'(1));
  assign oob_cnt_p1 = CNT_W'(oob_cnt + CNT_W'(1));
  assign err_set    = hs && (out_oob || (out_last && (cnt_p1 != CNT_W'(FRAME_LEN))));

  // Stage 1: raw offsets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_last  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dx   <= in_dx;
        s1_dy   <= in_dy;
        s1_last <= in_last;
      end
    end
  end

  // Stage 2: encoded index and out-of-bounds flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_oob   <= 1'b0;
      out_last  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_idx  <= {row5[3:0], col5[3:0]};
        out_oob  <= col5[4] | row5[4];
        out_last <= s1_last;
      end
    end
  end

  // Per-frame counters, frame pulse and sticky error (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      oob_cnt    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= hs && out_last;
      if (hs) begin
        if (out_last) begin
          cnt     <= '0;
          oob_cnt <= '0;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt_p1;
          if (out_oob && (oob_cnt != CNT_MAX)) oob_cnt <= oob_cnt_p1;
        end
      end
      if (err_set)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_win_offset_encoder.sv
// tb_win_offset_encoder
// Directed bench for win_offset_encoder: full in-range sweep, boundary
// offsets, backpressure/stall, short frame with err set/clear priority,
// and asynchronous reset mid-frame.
module tb_win_offset_encoder;

  typedef struct packed {
    logic [7:0] idx;
    logic       oob;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_dx;
  logic [4:0] in_dy;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_idx;
  logic       out_oob;
  logic       out_last;
  logic [8:0] cnt;
  logic [8:0] oob_cnt;
  logic       frame_done;
  logic       err;
  logic       clr_err;

  int n_chk = 0;
  int n_fail = 0;
  int fd_count = 0;
  int fd_before;
  int seq_next = 0;
  bit seq_mode = 0;
  bit acc;
  logic       obs_ir;
  logic       obs_ov;
  logic [7:0] obs_idx;
  exp_t exp_q[$];

  win_offset_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dx(in_dx), .in_dy(in_dy), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_oob(out_oob), .out_last(out_last),
    .cnt(cnt), .oob_cnt(oob_cnt), .frame_done(frame_done),
    .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding using plain signed integer arithmetic and range tests.
  function automatic exp_t model(input logic [4:0] dx, input logic [4:0] dy, input logic last);
    exp_t e;
    int sdx, sdy, r, c;
    sdx = int'($signed(dx));
    sdy = int'($signed(dy));
    r = 8 - sdy;
    c = 8 - sdx;
    e.idx  = {4'(r), 4'(c)};
    e.oob  = (sdx < -7) || (sdx > 8) || (sdy < -7) || (sdy > 8);
    e.last = last;
    return e;
  endfunction

  // One clock cycle: observe before the edge, score handshakes, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    obs_ir  = in_ready;
    obs_ov  = out_valid;
    obs_idx = out_idx;
    acc     = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_idx", 32'(out_idx), 32'(e.idx));
        check("out_oob", 32'(out_oob), 32'(e.oob));
        check("out_last", 32'(out_last), 32'(e.last));
        if (seq_mode) begin
          check("sweep_seq", 32'(out_idx), 32'(seq_next));
          seq_next++;
        end
      end
    end
    if (acc) exp_q.push_back(model(in_dx, in_dy, in_last));
    if (frame_done) fd_count++;
    @(posedge clk);
    #1;
  endtask

  // Present one sample until accepted; optionally randomise out_ready each cycle.
  task automatic send(input logic [4:0] dx, input logic [4:0] dy, input logic last, input bit rnd);
    int n;
    in_valid = 1'b1;
    in_dx    = dx;
    in_dy    = dy;
    in_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dx = '0; in_dy = '0; in_last = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full in-range sweep, idx 0..255 in order.
    seq_mode = 1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        send(5'(8 - c), 5'(8 - r), (r == 15) && (c == 15), 0);
    idle(4);
    seq_mode = 0;
    check("sweep_count", 32'(seq_next), 32'd256);
    check("sweep_fd", 32'(fd_count), 32'd1);
    check("sweep_cnt", 32'(cnt), 32'd0);
    check("sweep_oob_cnt", 32'(oob_cnt), 32'd0);
    check("sweep_err", 32'(err), 32'd0);

    // Boundary offsets.
    send(5'h18, 5'h00, 0, 0); idle(3);
    check("b_m8_idx", 32'(out_idx), 32'h80);
    check("b_m8_oob", 32'(out_oob), 32'd1);
    send(5'h09, 5'h00, 0, 0); idle(3);
    check("b_p9_idx", 32'(out_idx), 32'h8F);
    check("b_p9_oob", 32'(out_oob), 32'd1);
    send(5'h08, 5'h08, 0, 0); idle(3);
    check("b_p8_idx", 32'(out_idx), 32'h00);
    check("b_p8_oob", 32'(out_oob), 32'd0);
    send(5'h19, 5'h19, 0, 0); idle(3);
    check("b_m7_idx", 32'(out_idx), 32'hFF);
    check("b_m7_oob", 32'(out_oob), 32'd0);
    check("b_err", 32'(err), 32'd1);
    check("b_oob_cnt", 32'(oob_cnt), 32'd2);
    check("b_cnt", 32'(cnt), 32'd4);

    // Stall from an empty pipeline: in_ready drops on the 3rd stalled cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_dx = 5'd1; in_dy = 5'd2; in_last = 1'b0;
    cycle(); check("stall_c1_ready", 32'(obs_ir), 32'd1);
    in_dx = 5'd3; in_dy = 5'd4;
    cycle(); check("stall_c2_ready", 32'(obs_ir), 32'd1);
    in_dx = 5'd5; in_dy = 5'd6;
    for (int i = 3; i <= 5; i++) begin
      cycle();
      check("stall_ready_low", 32'(obs_ir), 32'd0);
      check("stall_idx_hold", 32'(obs_idx), 32'h67);
      check("stall_out_valid", 32'(obs_ov), 32'd1);
    end
    out_ready = 1'b1;
    send(5'd5, 5'd6, 0, 0);
    idle(4);

    // Random backpressure stream, frame closed by in_last.
    fd_before = fd_count;
    for (int i = 0; i < 30; i++)
      send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), i == 29, 1);
    out_ready = 1'b1;
    idle(6);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("bp_fd", 32'(fd_count - fd_before), 32'd1);
    check("bp_cnt", 32'(cnt), 32'd0);

    // Short frame of 10 in-range samples.
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    check("clr_before_short", 32'(err), 32'd0);
    fd_before = fd_count;
    for (int i = 0; i < 10; i++) send(5'(i - 3), 5'(2 - i), i == 9, 0);
    idle(3);
    check("short_fd", 32'(fd_count - fd_before), 32'd1);
    check("short_err", 32'(err), 32'd1);
    check("short_cnt", 32'(cnt), 32'd0);

    // Set and clear in the same cycle: set wins.
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    check("clr_err_alone0", 32'(err), 32'd0);
    send(5'h18, 5'h00, 0, 0);
    cycle();
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    check("set_clr_hs", 32'(obs_ov), 32'd1);
    check("set_wins", 32'(err), 32'd1);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    check("clr_err_alone", 32'(err), 32'd0);
    check("cnt_after_oob", 32'(cnt), 32'd1);

    // Bring cnt to 37 with two samples in flight, then reset asynchronously.
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 38; i++) begin
      in_dx = (i == 0) ? 5'h18 : 5'(i % 16 - 7);
      in_dy = 5'd0;
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_cnt", 32'(cnt), 32'd37);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_err", 32'(err), 32'd1);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_cnt", 32'(cnt), 32'd0);
    check("arst_oob_cnt", 32'(oob_cnt), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(5'd0, 5'd0, 0, 0);
    cycle(); check("post_rst_lat1", 32'(obs_ov), 32'd0);
    cycle(); check("post_rst_lat2", 32'(obs_ov), 32'd1);
    check("post_rst_idx", 32'(obs_idx), 32'h88);
    check("post_rst_cnt", 32'(cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
